// File: rtl/ula_sequencial_if.sv
// ula_sequencial_if: request/response bundle between the instruction decoder
// side (master) and the sequential ULA (slave). WIDTH must match the ULA's WIDTH.
interface ula_sequencial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       ula_operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             error;

  modport master (
    output start, ula_operation, a, b,
    input  busy, done, result, result_hi, carry, zero, error
  );

  modport slave (
    input  start, ula_operation, a, b,
    output busy, done, result, result_hi, carry, zero, error
  );
endinterface

// File: rtl/ula_sequencial.sv
// ula_sequencial: sequential ULA. Logic and add/sub ops finish in one EXEC
// cycle. MUL is iterative shift-add and DIV/MOD are restoring division, both
// WIDTH steps long. Results and flags are registered and announced by a
// one-cycle done pulse.
module ula_sequencial #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  ula_sequencial_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_MOD  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_XNOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    count;

  // acc_hi: MUL high half / DIV partial remainder; acc_lo: MUL low half / DIV quotient
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             is_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;

  logic [WIDTH-1:0] nxt_result;
  logic [WIDTH-1:0] nxt_result_hi;
  logic             nxt_carry;
  logic             nxt_zero;
  logic             nxt_error;
  logic             finishing;

  // MUL always iterates; DIV/MOD iterate only when the divisor is nonzero
  assign is_iter = (bus.ula_operation == OP_MUL) ||
                   (((bus.ula_operation == OP_DIV) || (bus.ula_operation == OP_MOD)) &&
                    (bus.b != '0));

  // One shift-add step: conditionally add b to the high half, then shift the pair right
  assign mul_sum = {1'b0, acc_hi} + ({1'b0, b_r} & {(WIDTH + 1){acc_lo[0]}});

  // One restoring step: bring in the next dividend bit, keep the trial only if non-negative
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_r};
  assign div_ok    = ~div_trial[WIDTH];

  assign finishing = (state == EXEC) || (state == FIN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: ITER runs until the down-counter reaches its final step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = is_iter ? ITER : EXEC;
      EXEC: state_nxt = IDLE;
      ITER: if (count == CW'(1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: busy flag and the values to be registered on the done edge
  always_comb begin
    bus.busy      = (state != IDLE);
    nxt_result    = '0;
    nxt_result_hi = '0;
    nxt_carry     = 1'b0;
    nxt_error     = 1'b0;
    if (state == FIN) begin
      case (op_r)
        OP_MUL: begin
          nxt_result    = acc_lo;
          nxt_result_hi = acc_hi;
        end
        OP_DIV: begin
          nxt_result    = acc_lo;
          nxt_result_hi = acc_hi;
        end
        OP_MOD: nxt_result = acc_hi;
        default: nxt_error = 1'b1;
      endcase
    end else begin
      case (op_r)
        OP_ADD: {nxt_carry, nxt_result} = {1'b0, a_r} + {1'b0, b_r};
        OP_SUB: begin
          nxt_result = a_r - b_r;
          nxt_carry  = (a_r < b_r);
        end
        OP_DIV, OP_MOD: begin
          nxt_result    = '1;
          nxt_result_hi = a_r;
          nxt_error     = 1'b1;
        end
        OP_AND:  nxt_result = a_r & b_r;
        OP_OR:   nxt_result = a_r | b_r;
        OP_XOR:  nxt_result = a_r ^ b_r;
        OP_NOT:  nxt_result = ~a_r;
        OP_NOR:  nxt_result = ~(a_r | b_r);
        OP_NAND: nxt_result = ~(a_r & b_r);
        OP_XNOR: nxt_result = ~(a_r ^ b_r);
        default: nxt_error = 1'b1;
      endcase
    end
    nxt_zero = (nxt_result == '0);
  end

  // Operand capture in IDLE and one iteration step per cycle in ITER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r   <= bus.ula_operation;
            a_r    <= bus.a;
            b_r    <= bus.b;
            count  <= CW'(WIDTH);
            acc_hi <= '0;
            acc_lo <= bus.a;
          end
        end
        ITER: begin
          count <= count - CW'(1);
          if (op_r == OP_MUL) begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else begin
            acc_hi <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: load and pulse done only when leaving EXEC or FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.carry     <= 1'b0;
      bus.zero      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.done <= finishing;
      if (finishing) begin
        bus.result    <= nxt_result;
        bus.result_hi <= nxt_result_hi;
        bus.carry     <= nxt_carry;
        bus.zero      <= nxt_zero;
        bus.error     <= nxt_error;
      end
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
// tb_ula_sequencial: scoreboard bench for ula_sequencial. The driver pushes the
// reference model's expectation when a request is issued; a monitor pops and
// compares on every done pulse, including the edge at which done arrived.
module tb_ula_sequencial;

  localparam int W  = 8;
  localparam int W2 = 2 * W;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         carry;
    logic         zero;
    logic         error;
    int           done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vectors;
  int   n_miscompares;
  exp_t sb[$];

  ula_sequencial_if #(.WIDTH(W)) bus ();

  ula_sequencial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so latencies can be checked in whole cycles
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain unsigned arithmetic; done_cyc carries the latency
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t          e;
    logic [W2-1:0] p;
    e.op       = op;
    e.result   = '0;
    e.hi       = '0;
    e.carry    = 1'b0;
    e.error    = 1'b0;
    e.done_cyc = 1;
    p          = '0;
    case (op)
      4'd1: begin
        p        = W2'(a) + W2'(b);
        e.result = p[W-1:0];
        e.carry  = p[W];
      end
      4'd2: begin
        e.result = a - b;
        e.carry  = (a < b);
      end
      4'd3: begin
        p          = W2'(a) * W2'(b);
        e.result   = p[W-1:0];
        e.hi       = p[W2-1:W];
        e.done_cyc = W + 1;
      end
      4'd4, 4'd5: begin
        if (b == '0) begin
          e.result = '1;
          e.hi     = a;
          e.error  = 1'b1;
        end else begin
          e.result   = (op == 4'd4) ? a / b : a % b;
          e.hi       = (op == 4'd4) ? a % b : '0;
          e.done_cyc = W + 1;
        end
      end
      4'd6:  e.result = a & b;
      4'd7:  e.result = a | b;
      4'd8:  e.result = a ^ b;
      4'd9:  e.result = ~a;
      4'd10: e.result = ~(a | b);
      4'd11: e.result = ~(a & b);
      4'd12: e.result = ~(a ^ b);
      default: e.error = 1'b1;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    n_vectors++;
    n_miscompares++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Issue one request as soon as the ULA is free and record what it must answer
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] av,
                               input logic [W-1:0] bv);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (bus.busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bus.busy) begin
      reportFail("busy_timeout");
      return;
    end
    bus.start         = 1'b1;
    bus.ula_operation = op;
    bus.a             = av;
    bus.b             = bv;
    e                 = model(op, av, bv);
    e.done_cyc        = cyc + 1 + e.done_cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},      32'(bus.busy),      32'd0);
    checkOutput({tag, "_done"},      32'(bus.done),      32'd0);
    checkOutput({tag, "_result"},    32'(bus.result),    32'd0);
    checkOutput({tag, "_result_hi"}, 32'(bus.result_hi), 32'd0);
    checkOutput({tag, "_carry"},     32'(bus.carry),     32'd0);
    checkOutput({tag, "_zero"},      32'(bus.zero),      32'd0);
    checkOutput({tag, "_error"},     32'(bus.error),     32'd0);
  endtask

  // Monitor: compare every done pulse against the oldest expectation
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        checkOutput("done_twice", 32'(prev_done), 32'd0);
        checkOutput("busy_in_done", 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
          reportFail("unexpected_done");
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("op%0d_result", e.op),    32'(bus.result),    32'(e.result));
          checkOutput($sformatf("op%0d_result_hi", e.op), 32'(bus.result_hi), 32'(e.hi));
          checkOutput($sformatf("op%0d_carry", e.op),     32'(bus.carry),     32'(e.carry));
          checkOutput($sformatf("op%0d_zero", e.op),      32'(bus.zero),      32'(e.zero));
          checkOutput($sformatf("op%0d_error", e.op),     32'(bus.error),     32'(e.error));
          checkOutput($sformatf("op%0d_done_cycle", e.op), 32'(cyc),          32'(e.done_cyc));
        end
      end else if (sb.size() > 0 && sb[0].done_cyc < cyc) begin
        e = sb.pop_front();
        reportFail($sformatf("op%0d_missed_done", e.op));
      end
      prev_done = bus.done;
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int drain;
    n_vectors         = 0;
    n_miscompares     = 0;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.ula_operation = '0;
    bus.a             = '0;
    bus.b             = '0;

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("idle_done", 32'(bus.done), 32'd0);
    end

    applyStimulus(4'b0001, 8'd200, 8'd100);
    applyStimulus(4'b0010, 8'd5, 8'd5);

    applyStimulus(4'b0011, 8'd255, 8'd255);
    repeat (3) begin
      @(negedge clk);
      bus.start         = 1'b1;
      bus.ula_operation = 4'b0001;
      bus.a             = W'($urandom);
      bus.b             = W'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;

    applyStimulus(4'b0100, 8'd200, 8'd7);
    applyStimulus(4'b0101, 8'd200, 8'd7);
    applyStimulus(4'b0100, 8'h55, 8'h00);
    applyStimulus(4'b1110, W'($urandom), W'($urandom));

    applyStimulus(4'b0100, 8'd200, 8'd7);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'b0001, 8'd17, 8'd25);
    applyStimulus(4'b1001, 8'h0F, W'($urandom));
    applyStimulus(4'b1100, 8'hF0, 8'h0F);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 4'($urandom_range(0, 15));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(rop, ra, rb);
    end

    drain = 0;
    while (sb.size() > 0 && drain < 200) begin
      @(posedge clk);
      drain++;
    end
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) reportFail("drain_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
